// File: rtl/multicycle_controller.sv
// RV32I multi-cycle control FSM: Moore decode of state (BRANCH PCWrite is Mealy on Zero;
// ALUControl follows funct bits in EXEC states; ImmSrc is decoded from op only). No backpressure.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    LUI      = 4'd8,
    JAL      = 4'd9,
    ALUWB    = 4'd10,
    BRANCH   = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  state_t     state, next_state;
  logic       mem_write_s, reg_write_s, ir_write_s, pc_write_s, illegal_s, done_s;
  logic [2:0] funct_ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

  // Only R-type (op[5] set) may select subtract; addi ignores bit 30.
  always_comb begin
    funct_ctrl = 3'b000;
    case (funct3)
      3'b000:  funct_ctrl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
      3'b010:  funct_ctrl = 3'b101;
      3'b100:  funct_ctrl = 3'b100;
      3'b110:  funct_ctrl = 3'b011;
      3'b111:  funct_ctrl = 3'b010;
      default: funct_ctrl = 3'b000;
    endcase
  end

  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_STORE: ImmSrc = 3'b001;
      OP_BR:    ImmSrc = 3'b010;
      OP_JAL:   ImmSrc = 3'b011;
      OP_LUI:   ImmSrc = 3'b100;
      default:  ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    next_state  = FETCH;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    ir_write_s  = 1'b0;
    pc_write_s  = 1'b0;
    illegal_s   = 1'b0;
    done_s      = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUControl  = 3'b000;
    case (state)
      FETCH: begin
        ir_write_s = 1'b1;
        pc_write_s = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        next_state = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: next_state = MEMADR;
          OP_R:              next_state = EXECR;
          OP_I:              next_state = EXECI;
          OP_BR:             next_state = BRANCH;
          OP_JAL:            next_state = JAL;
          OP_LUI:            next_state = LUI;
          default: begin
            next_state = FETCH;
            illegal_s  = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        next_state = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_s = 1'b1;
        done_s      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
        done_s      = 1'b1;
      end
      EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = funct_ctrl;
        next_state = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = funct_ctrl;
        next_state = ALUWB;
      end
      LUI: begin
        ALUSrcA    = 2'b11;
        ALUSrcB    = 2'b01;
        next_state = ALUWB;
      end
      JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_write_s = 1'b1;
        next_state = ALUWB;
      end
      ALUWB: begin
        reg_write_s = 1'b1;
        done_s      = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        pc_write_s = Zero ^ funct3[0];
        done_s     = 1'b1;
      end
      default: next_state = FETCH;
    endcase
  end

  // Enables are held off combinationally while reset is low.
  assign MemWrite   = mem_write_s & reset;
  assign RegWrite   = reg_write_s & reset;
  assign IRWrite    = ir_write_s  & reset;
  assign PCWrite    = pc_write_s  & reset;
  assign illegal    = illegal_s   & reset;
  assign instr_done = done_s      & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          instr_count <= '0;
    else if (instr_done) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the RV32I multi-cycle datapath. Sequences fetch, decode, execute, memory and writeback by driving every datapath enable and mux select.
- Decodes op, funct3 and funct7[5] from the instruction register. Reports illegal opcodes and counts retired instructions.
- Sits beside the datapath, which feeds back Zero and the instruction fields.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
op  input  7  InstrReg[6:0]
funct3  input  3  InstrReg[14:12]
funct7b5  input  1  InstrReg[30]
Zero  input  1  ALU zero flag
MemWrite  output  1  memory write enable
RegWrite  output  1  register file write enable
IRWrite  output  1  instruction register / OldPC load
PCWrite  output  1  PC load
AdrSrc  output  1  memory address select: 0 = PC, 1 = Result
ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = A, 11 = zero
ALUSrcB  output  2  00 = WriteData, 01 = ImmExt, 10 = 4
ImmSrc  output  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
illegal  output  1  one-cycle pulse on an unsupported opcode
instr_done  output  1  one-cycle pulse in the last state of each instruction
instr_count  output  CNT_W  retired-instruction count

Behaviour:
- State register is 4 bits. Reset (reset = 0) forces state to FETCH and instr_count to 0 asynchronously.
- While reset is low: MemWrite, RegWrite, IRWrite, PCWrite, illegal and instr_done are forced to 0. All other outputs take their FETCH values.
- Outputs are Moore decodes of state, with two exceptions:
  - PCWrite in BRANCH depends on Zero (Mealy).
  - ImmSrc and ALUControl are combinational on op, funct3 and funct7b5.
- Any output not listed for a state is 0.
- State table (state: asserted outputs -> next state):
  - FETCH: AdrSrc=0, IRWrite, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite -> DECODE
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jump target into ALUOut). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 0110111 -> LUI
    - any other op -> FETCH, with illegal = 1 for this cycle
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add -> MEMREAD if op = 0000011, else MEMWRITE
  - MEMREAD: AdrSrc=1, ResultSrc=00 -> MEMWB
  - MEMWB: ResultSrc=01, RegWrite, instr_done -> FETCH
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite, instr_done -> FETCH
  - EXECR: ALUSrcA=10, ALUSrcB=00, funct decode -> ALUWB
  - EXECI: ALUSrcA=10, ALUSrcB=01, funct decode -> ALUWB
  - LUI: ALUSrcA=11, ALUSrcB=01, add -> ALUWB
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite -> ALUWB
  - ALUWB: ResultSrc=00, RegWrite, instr_done -> FETCH
  - BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite = Zero XOR funct3[0] (beq/bne), instr_done -> FETCH
- Unused state encodings go to FETCH on the next clock with no write enables asserted.
- ImmSrc by op:
  - 0100011 -> S
  - 1100011 -> B
  - 1101111 -> J
  - 0110111 -> U
  - otherwise -> I
- Funct decode (EXECR/EXECI) by funct3:
  - 000 -> sub if op[5] & funct7b5 (R-type only), else add
  - 010 -> slt
  - 100 -> xor
  - 110 -> or
  - 111 -> and
  - anything else -> add
- Cycle counts per instruction, FETCH included: lw 5, sw 4, R/I-ALU 4, lui 4, jal 4, branch 3, illegal 2.
- instr_count increments by 1 on the clock edge where instr_done = 1. It wraps from all-ones to 0. An illegal instruction does not count.
- Reset asserted mid-instruction aborts the instruction. No write enable is asserted after reset is released until FETCH is re-entered normally.

Test Plan:
- Reset low 3 cycles, then release; hold op = 0x33 -> FETCH outputs IRWrite = 1, PCWrite = 1, ALUSrcB = 10, ResultSrc = 10 on the first cycle; write enables = 0 while in reset; instr_count = 0.
- lw (op 0x03) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite = 1 only in cycle 5 with ResultSrc = 01; instr_count = 1.
- sw (op 0x23) -> MemWrite = 1 only in cycle 4 with AdrSrc = 1; ImmSrc = 001.
- add then sub (op 0x33, funct3 000, funct7b5 = 0, then 1) -> ALUControl = 000 then 001 in EXECR; addi with funct7b5 = 1 gives ALUControl = 000.
- beq (funct3 000) with Zero = 1 -> PCWrite = 1 in BRANCH; with Zero = 0 -> PCWrite = 0; bne (funct3 001) inverts both; 3 cycles each.
- op 0x7F -> illegal pulses in DECODE, next state FETCH, instr_count unchanged; reset asserted during MEMREAD -> state returns to FETCH and RegWrite is never asserted.
